clint_timer: RTL and testbench

Memory-mapped machine timer slave that sits on the core's data bus beside main memory. It decodes the CLINT window and maintains a 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register. It drives the `timer_int` line, which the SoC top packs into bit 0 of the core's `I_int` vector. Bus semantics match the core dbus (req/we/addr/data/mask) plus a `ready` strobe, so the top can steer dbus traffic here instead of `pmem_read`/`pmem_write` when the address hits the window.

---
 rtl/clint_timer.sv | 118 +++++++++++
 tb/tb_clint_timer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// CLINT machine timer: 64-bit mtime/mtimecmp behind a req/ready dbus slave.
// O_timer_int is a registered level compare; every request completes in two cycles.
module clint_timer #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        I_req,
   input  logic        I_we,
   input  logic [31:0] I_addr,
   input  logic [31:0] I_data,
   input  logic [3:0]  I_mask,
   output logic [31:0] O_data,
   output logic        O_ready,
   output logic        O_timer_int
);

   localparam logic [15:0] PRESC_MAX = PRESCALE[15:0] - 16'd1;
   localparam logic [29:0] BASE_W    = BASE_ADDR[31:2];

   localparam logic [13:0] W_CMP_LO = 14'h1000;
   localparam logic [13:0] W_CMP_HI = 14'h1001;
   localparam logic [13:0] W_MT_LO  = 14'h2FFE;
   localparam logic [13:0] W_MT_HI  = 14'h2FFF;

   typedef enum logic {S_IDLE, S_RESP} state_e;

   state_e      state_q;
   logic [15:0] presc_q, presc_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [31:0] data_q;
   logic        ready_q;
   logic        int_q;

   logic [29:0] woff;
   logic        in_win;
   logic        sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
   logic        wr;
   logic        tick;
   logic [31:0] rdata;
   logic        unused_addr;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] m);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = m[b] ? wd[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   assign unused_addr = ^I_addr[1:0];

   // Word offset from the base; anything above 64 KiB falls outside the window.
   assign woff       = I_addr[31:2] - BASE_W;
   assign in_win     = (woff[29:14] == 16'h0);
   assign sel_cmp_lo = in_win && (woff[13:0] == W_CMP_LO);
   assign sel_cmp_hi = in_win && (woff[13:0] == W_CMP_HI);
   assign sel_mt_lo  = in_win && (woff[13:0] == W_MT_LO);
   assign sel_mt_hi  = in_win && (woff[13:0] == W_MT_HI);

   assign wr   = (state_q == S_IDLE) && I_req && I_we && (I_mask != 4'b0000);
   assign tick = (presc_q == PRESC_MAX);

   always_comb begin
      presc_d    = tick ? 16'd0 : presc_q + 16'd1;
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
      rdata      = 32'h0;
      if (sel_cmp_lo) rdata = mtimecmp_q[31:0];
      if (sel_cmp_hi) rdata = mtimecmp_q[63:32];
      if (sel_mt_lo)  rdata = mtime_q[31:0];
      if (sel_mt_hi)  rdata = mtime_q[63:32];
      // An mtime write drops that cycle's tick for both halves, so no carry leaks across.
      if (wr && sel_mt_lo) mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], I_data, I_mask)};
      if (wr && sel_mt_hi) mtime_d = {merge(mtime_q[63:32], I_data, I_mask), mtime_q[31:0]};
      if (wr && sel_cmp_lo)
         mtimecmp_d = {mtimecmp_q[63:32], merge(mtimecmp_q[31:0], I_data, I_mask)};
      if (wr && sel_cmp_hi)
         mtimecmp_d = {merge(mtimecmp_q[63:32], I_data, I_mask), mtimecmp_q[31:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         presc_q    <= 16'd0;
         mtime_q    <= 64'd0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         data_q     <= 32'h0;
         ready_q    <= 1'b0;
         int_q      <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         int_q      <= (mtime_q >= mtimecmp_q);
         case (state_q)
            S_IDLE: begin
               ready_q <= 1'b0;
               if (I_req) begin
                  state_q <= S_RESP;
                  ready_q <= 1'b1;
                  data_q  <= I_we ? 32'h0 : rdata;
               end
            end
            default: begin
               ready_q <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign O_data      = data_q;
   assign O_ready     = ready_q;
   assign O_timer_int = int_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: PRESCALE=1 and PRESCALE=4 instances on a shared bus,
// read results scoreboarded through a queue and checked with immediate assertions.
module tb_clint_timer;
   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk = 1'b0, rst = 1'b1;
   logic        req1 = 1'b0, req4 = 1'b0, we = 1'b0;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic [3:0]  mask = 4'h0;
   logic [31:0] rd1, rd4;
   logic        rdy1, rdy4, int1, int4;

   int checks = 0, failures = 0;
   int edges = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   clint_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut (
      .clk(clk), .rst(rst), .I_req(req1), .I_we(we), .I_addr(addr), .I_data(wdata),
      .I_mask(mask), .O_data(rd1), .O_ready(rdy1), .O_timer_int(int1));

   clint_timer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .I_req(req4), .I_we(we), .I_addr(addr), .I_data(wdata),
      .I_mask(mask), .O_data(rd4), .O_ready(rdy4), .O_timer_int(int4));

   always #5 clk = ~clk;

   // Rising edges seen out of reset: equals mtime of an unwritten PRESCALE=1 counter.
   always @(posedge clk or posedge rst)
      if (rst) edges <= 0;
      else     edges <= edges + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the access is sampled on the next rising edge.
   task automatic access(input bit d4, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic [31:0] exp, input string tag,
                         output logic int_rdy);
      logic        got;
      logic [31:0] e;
      string       t;
      we = w; addr = a; wdata = d; mask = m;
      if (d4) req4 = 1'b1; else req1 = 1'b1;
      exp_q.push_back(w ? 32'h0 : exp);
      tag_q.push_back(tag);
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         got = d4 ? rdy4 : rdy1;
      end
      req1 = 1'b0; req4 = 1'b0;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      int_rdy = d4 ? int4 : int1;
      chk({t, "_ready"}, got, 1);
      chk(t, d4 ? rd4 : rd1, e);
      @(negedge clk);
      chk({t, "_pulse"}, d4 ? rdy4 : rdy1, 0);
      chk({t, "_hold"}, d4 ? rd4 : rd1, e);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic ir;
      @(negedge clk);
      chk("rst_ready", rdy1, 0);
      chk("rst_data", rd1, 0);
      chk("rst_int", int1, 0);
      chk("rst_ready4", rdy4, 0);
      rst = 1'b0;

      repeat (10) begin
         @(negedge clk);
         chk("idle_int", int1, 0);
      end
      access(0, 0, BASE + 32'hBFF8, 0, 0, edges, "mt_lo_idle", ir);
      access(0, 0, BASE + 32'hBFFC, 0, 0, 0, "mt_hi_idle", ir);

      // Compare at 20: interrupt rises one edge after mtime reaches 20
      access(0, 1, BASE + 32'h4000, 32'd20, 4'hF, 0, "wr_cmp_lo", ir);
      access(0, 1, BASE + 32'h4004, 32'd0, 4'hF, 0, "wr_cmp_hi", ir);
      while (edges < 20) begin
         @(negedge clk);
         chk("int_before", int1, 0);
      end
      @(negedge clk);
      chk("int_rise", int1, 1);
      access(0, 1, BASE + 32'h4004, 32'd1, 4'hF, 0, "wr_cmp_hi1", ir);
      chk("int_at_wr", ir, 1);
      chk("int_fall", int1, 0);

      // Carry from lo into hi
      access(0, 1, BASE + 32'hBFFC, 32'h0, 4'hF, 0, "wr_mt_hi0", ir);
      access(0, 1, BASE + 32'hBFF8, 32'hFFFF_FFFE, 4'hF, 0, "wr_mt_lo", ir);
      access(0, 0, BASE + 32'hBFF8, 0, 0, 32'hFFFF_FFFF, "carry_lo_pre", ir);
      access(0, 0, BASE + 32'hBFFC, 0, 0, 32'h1, "carry_hi", ir);
      access(0, 0, BASE + 32'hBFF8, 0, 0, 32'h3, "carry_lo", ir);

      // 64-bit wrap to zero
      access(0, 1, BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, 0, "wr_mt_hiF", ir);
      access(0, 1, BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, 0, "wr_mt_loF", ir);
      access(0, 0, BASE + 32'hBFFC, 0, 0, 32'h0, "wrap_hi", ir);
      access(0, 0, BASE + 32'hBFF8, 0, 0, 32'h2, "wrap_lo", ir);

      // Byte enables
      access(0, 1, BASE + 32'h4000, 32'h1122_3344, 4'hF, 0, "wr_cmp_full", ir);
      access(0, 1, BASE + 32'h4000, 32'hAABB_CCDD, 4'b0101, 0, "wr_cmp_mask", ir);
      access(0, 0, BASE + 32'h4000, 0, 0, 32'h11BB_33DD, "mask_rd", ir);
      access(0, 1, BASE + 32'h4000, 32'h0, 4'b0000, 0, "wr_mask0", ir);
      access(0, 0, BASE + 32'h4000, 0, 0, 32'h11BB_33DD, "mask0_rd", ir);

      // Unmapped and out-of-window accesses
      access(0, 0, BASE + 32'h0010, 0, 0, 32'h0, "unmap_rd", ir);
      access(0, 0, 32'h8000_0000, 0, 0, 32'h0, "outwin_rd", ir);
      access(0, 1, BASE + 32'h0010, 32'hFFFF_FFFF, 4'hF, 0, "unmap_wr", ir);
      access(0, 1, 32'h8000_4000, 32'h0, 4'hF, 0, "outwin_wr_cmp", ir);
      access(0, 1, 32'h8000_BFFC, 32'hDEAD, 4'hF, 0, "outwin_wr_mt", ir);
      access(0, 0, BASE + 32'h4000, 0, 0, 32'h11BB_33DD, "unmap_cmp_lo", ir);
      access(0, 0, BASE + 32'h4004, 0, 0, 32'h1, "unmap_cmp_hi", ir);
      access(0, 0, BASE + 32'hBFFC, 0, 0, 32'h0, "unmap_mt_hi", ir);

      // PRESCALE=4: mtime before edge edges+1 is edges/4
      repeat (3) begin
         access(1, 0, BASE + 32'hBFF8, 0, 0, 32'(edges / 4), "p4_lo", ir);
         repeat (2) @(negedge clk);
      end
      access(1, 0, BASE + 32'hBFFC, 0, 0, 32'h0, "p4_hi", ir);
      while (edges % 4 != 3) @(negedge clk);
      access(1, 1, BASE + 32'hBFF8, 32'h100, 4'hF, 0, "p4_wr_tick", ir);
      access(1, 0, BASE + 32'hBFF8, 0, 0, 32'h100, "p4_tick_exact", ir);
      access(1, 0, BASE + 32'hBFF8, 0, 0, 32'h100, "p4_same", ir);
      access(1, 0, BASE + 32'hBFF8, 0, 0, 32'h101, "p4_next", ir);

      // Reset during RESP
      access(0, 1, BASE + 32'h4004, 32'h0, 4'hF, 0, "wr_cmp_hi_z", ir);
      access(0, 1, BASE + 32'h4000, 32'h0, 4'hF, 0, "wr_cmp_lo_z", ir);
      @(negedge clk);
      chk("int_cmp0", int1, 1);
      we = 1'b0; addr = BASE + 32'hBFF8; mask = 4'h0; req1 = 1'b1;
      @(negedge clk);
      chk("rsp_ready", rdy1, 1);
      rst = 1'b1;
      #1;
      chk("rstmid_ready", rdy1, 0);
      chk("rstmid_data", rd1, 0);
      chk("rstmid_int", int1, 0);
      @(negedge clk);
      req1 = 1'b0;
      rst = 1'b0;
      access(0, 0, BASE + 32'h4000, 0, 0, 32'hFFFF_FFFF, "post_rst_cmp_lo", ir);
      access(0, 0, BASE + 32'h4004, 0, 0, 32'hFFFF_FFFF, "post_rst_cmp_hi", ir);
      access(0, 0, BASE + 32'hBFF8, 0, 0, 32'(edges), "post_rst_mt_lo", ir);
      chk("post_rst_int", int1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
